// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer.
// Contents:
//   - OP_* constants: opcode encodings for the non-ALU instructions
//     (opcodes 0-7 go straight to the ALU).
//   - state_t: the sequencer FSM states.
//   - instr_t: the field layout of a 16-bit instruction word.
//   - is_alu_op: returns 1 for opcodes 0-7.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // Instruction word: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } instr_t;

    // Opcodes with bit 3 clear are forwarded to the external ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4-entry register file for the ALU control sequencer.
// Ports:
//   clk, reset          clock and synchronous active-high reset (clears all entries)
//   we, waddr, wdata    synchronous write port
//   raddr_a, rdata_a    asynchronous read port A
//   raddr_b, rdata_b    asynchronous read port B
module alu_ctrl_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [1:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_r [4];

    // Register storage; reset takes priority over a write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Control unit that drives an external combinational ALU.
// Executes a program held in internal program memory.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   prog_we                program-memory write strobe (ignored while busy)
//   prog_addr, prog_data   program-memory write address and instruction word
//   start                  pulse that starts execution at PC=0 (ignored while busy)
//   busy                   high while a program is running
//   done                   1-cycle pulse in the EXEC cycle of HALT
//   alu_a, alu_b, alu_op   ALU operands R[rd], R[rs] and opcode, taken from IR
//   alu_r, alu_zero        ALU result and zero flag
//   out_data, out_valid    output register and its 1-cycle strobe
module alu_ctrl_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int PROG_AW = 4,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_r,
    input  logic               alu_zero,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid
);

    localparam int PROG_DEPTH = 2 ** PROG_AW;

    logic [15:0]        mem_r [PROG_DEPTH];
    state_t             state_r;
    state_t             state_nx_s;
    logic [PROG_AW-1:0] pc_r;
    logic [PROG_AW-1:0] pc_nx_s;
    instr_t             ir_r;
    logic               z_r;
    logic [DATA_W-1:0]  res_r;
    logic               busy_r;
    logic               done_r;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic [15:0]        fetch_word_s;
    logic               rf_we_s;
    logic [DATA_W-1:0]  rf_wdata_s;
    logic [DATA_W-1:0]  rd_val_s;
    logic [DATA_W-1:0]  rs_val_s;

    alu_ctrl_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we_s),
        .waddr   (ir_r.rd),
        .wdata   (rf_wdata_s),
        .raddr_a (ir_r.rd),
        .rdata_a (rd_val_s),
        .raddr_b (ir_r.rs),
        .rdata_b (rs_val_s)
    );

    assign fetch_word_s = mem_r[pc_r];
    assign alu_a        = rd_val_s;
    assign alu_b        = rs_val_s;
    assign alu_op       = ir_r.op[2:0];
    assign busy         = busy_r;
    assign done         = done_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;

    // Program memory write port; contents survive reset so a program need not be reloaded
    always_ff @(posedge clk) begin
        if (prog_we && !busy_r) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nx_s = ST_EXEC;
            ST_EXEC: begin
                if (is_alu_op(ir_r.op)) begin
                    state_nx_s = ST_WB;
                end else if (ir_r.op == OP_HALT) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_WB:   state_nx_s = ST_FETCH;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: register-file write control and next PC
    always_comb begin
        rf_we_s    = 1'b0;
        rf_wdata_s = res_r;
        pc_nx_s    = pc_r + {{(PROG_AW-1){1'b0}}, 1'b1};
        case (state_r)
            ST_EXEC: begin
                if (ir_r.op == OP_LDI) begin
                    rf_we_s    = 1'b1;
                    rf_wdata_s = DATA_W'(ir_r.imm);
                end else begin
                    rf_we_s    = 1'b0;
                end
                if ((ir_r.op == OP_JMP) || ((ir_r.op == OP_JZ) && z_r)) begin
                    pc_nx_s = ir_r.imm[PROG_AW-1:0];
                end else begin
                    pc_nx_s = pc_r + {{(PROG_AW-1){1'b0}}, 1'b1};
                end
            end
            ST_WB: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = res_r;
            end
            default: begin
                rf_we_s = 1'b0;
            end
        endcase
    end

    // Datapath registers: PC, IR, zero flag, ALU result and output strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= {PROG_AW{1'b0}};
            ir_r        <= instr_t'(16'h0000);
            z_r         <= 1'b0;
            res_r       <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pc_r   <= {PROG_AW{1'b0}};
                        z_r    <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    ir_r   <= instr_t'(fetch_word_s);
                    // Decided one cycle early so that done is registered yet lands in the HALT EXEC cycle
                    done_r <= (fetch_word_s[15:12] == OP_HALT);
                end
                ST_EXEC: begin
                    pc_r <= pc_nx_s;
                    if (is_alu_op(ir_r.op)) begin
                        res_r <= alu_r;
                        z_r   <= alu_zero;
                    end
                    if (ir_r.op == OP_OUT) begin
                        out_data_r  <= rd_val_s;
                        out_valid_r <= 1'b1;
                    end
                    if (ir_r.op == OP_HALT) begin
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

endmodule
